// File: rtl/c3aibadapt_avmm_ssr_pkg.sv
// ============================================================================
// Module   : c3aibadapt_avmm_ssr_pkg
// Brief    : Shared SSR frame constants and state encoding (TX and far-end RX)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package c3aibadapt_avmm_ssr_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CAPT  = 3'd2,
      SHIFT = 3'd3,
      GAP   = 3'd4
   } ssr_state_e;

   localparam int SSR_FRAME_CNT_W = 8;
   localparam int SSR_GAP_CNT_W   = 4;

   // Cycles from one ssr_load strobe to the next while running continuously.
   function automatic int ssr_frame_period(input int dwidth, input int gap_cycles);
      return 2 + dwidth + gap_cycles;
   endfunction

endpackage

`default_nettype wire

// File: rtl/c3aibadapt_avmm_ssr_shreg.sv
// ============================================================================
// Module   : c3aibadapt_avmm_ssr_shreg
// Brief    : Parallel-load, right-shift register with registered serial output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c3aibadapt_avmm_ssr_shreg #(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic              drive_i,
   input  logic [DWIDTH-1:0] din_i,
   output logic              sout_o
);

   logic [DWIDTH-1:0] shreg_q;
   logic [DWIDTH-1:0] shreg_d;
   logic              sout_q;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = din_i;
      end else if (shift_i) begin
         shreg_d = shreg_q >> 1;
      end
   end

   // sout is loaded with the LSB the register is about to hold, so the pin
   // shows bit n in the same cycle the register holds it, straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         sout_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         sout_q  <= drive_i & shreg_d[0];
      end
   end

   assign sout_o = sout_q;

endmodule

`default_nettype wire

// File: rtl/c3aibadapt_avmm_ssr_tx.sv
// ============================================================================
// Module   : c3aibadapt_avmm_ssr_tx
// Brief    : SSR transmitter - periodic unload, capture and LSB-first framing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c3aibadapt_avmm_ssr_tx
   import c3aibadapt_avmm_ssr_pkg::*;
#(
   parameter int DWIDTH     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                       avmm_clock_ssr_clk,
   input  logic                       avmm_reset_ssr_clk_rst,
   input  logic                       sr_enable,
   input  logic [DWIDTH-1:0]          ssr_par_data_in,
   output logic                       ssr_load,
   output logic                       ssr_sdata_out,
   output logic                       ssr_sof_out,
   output logic                       ssr_frame_done,
   output logic                       ssr_busy,
   output logic [SSR_FRAME_CNT_W-1:0] ssr_frame_cnt
);

   localparam int                       BCNT_W   = $clog2(DWIDTH + 1);
   localparam logic [BCNT_W-1:0]        BIT_LAST = BCNT_W'(DWIDTH - 1);
   localparam logic [SSR_GAP_CNT_W-1:0] GAP_LAST =
      SSR_GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   ssr_state_e                 state_q, state_d;
   logic [BCNT_W-1:0]          bitcnt_q, bitcnt_d;
   logic [SSR_GAP_CNT_W-1:0]   gapcnt_q, gapcnt_d;
   logic [SSR_FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
   logic                       load_q, load_d;
   logic                       sof_q, sof_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       w_last_bit;
   logic                       w_last_gap;

   assign w_last_bit = (state_q == SHIFT) && (bitcnt_q == BIT_LAST);
   assign w_last_gap = (state_q == GAP) && (gapcnt_q == GAP_LAST);

   always_ff @(posedge avmm_clock_ssr_clk or posedge avmm_reset_ssr_clk_rst) begin
      if (avmm_reset_ssr_clk_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // sr_enable is only consulted at frame boundaries, so a drop mid-frame
   // always lets the current frame and its gap finish.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sr_enable) state_d = LOAD;
         LOAD:    state_d = CAPT;
         CAPT:    state_d = SHIFT;
         SHIFT:   if (w_last_bit) begin
                     if (GAP_CYCLES > 0) state_d = GAP;
                     else                state_d = sr_enable ? LOAD : IDLE;
                  end
         GAP:     if (w_last_gap) state_d = sr_enable ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes from a flop.
   always_comb begin
      bitcnt_d = ((state_q == SHIFT) && !w_last_bit) ? bitcnt_q + 1'b1 : '0;
      gapcnt_d = ((state_q == GAP) && !w_last_gap) ? gapcnt_q + 1'b1 : '0;
      fcnt_d   = w_last_bit ? fcnt_q + 1'b1 : fcnt_q;
      load_d   = (state_d == LOAD);
      busy_d   = (state_d != IDLE);
      sof_d    = (state_d == SHIFT) && (bitcnt_d == '0);
      done_d   = (state_d == SHIFT) && (bitcnt_d == BIT_LAST);
   end

   always_ff @(posedge avmm_clock_ssr_clk or posedge avmm_reset_ssr_clk_rst) begin
      if (avmm_reset_ssr_clk_rst) begin
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         fcnt_q   <= '0;
         load_q   <= 1'b0;
         sof_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         fcnt_q   <= fcnt_d;
         load_q   <= load_d;
         sof_q    <= sof_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   c3aibadapt_avmm_ssr_shreg #(
      .DWIDTH (DWIDTH)
   ) u_shreg (
      .clk     (avmm_clock_ssr_clk),
      .rst     (avmm_reset_ssr_clk_rst),
      .load_i  (state_q == CAPT),
      .shift_i (state_q == SHIFT),
      .drive_i (state_d == SHIFT),
      .din_i   (ssr_par_data_in),
      .sout_o  (ssr_sdata_out)
   );

   assign ssr_load       = load_q;
   assign ssr_sof_out    = sof_q;
   assign ssr_frame_done = done_q;
   assign ssr_busy       = busy_q;
   assign ssr_frame_cnt  = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_c3aibadapt_avmm_ssr_tx.sv
// ============================================================================
// Module   : tb_c3aibadapt_avmm_ssr_tx
// Brief    : Self-checking bench: default instance plus DWIDTH=1/GAP=0 instance
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c3aibadapt_avmm_ssr_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_en, b_en;
   logic [7:0] a_par;
   logic [0:0] b_par;
   logic       a_load, a_sdata, a_sof, a_done, a_busy;
   logic       b_load, b_sdata, b_sof, b_done, b_busy;
   logic [7:0] a_cnt, b_cnt;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];

   int         mon_idx = 0;
   bit         mon_act = 1'b0;
   logic [7:0] mon_word = '0;

   always #5 clk = ~clk;

   c3aibadapt_avmm_ssr_tx #(.DWIDTH(8), .GAP_CYCLES(2)) u_dut_a (
      .avmm_clock_ssr_clk     (clk),
      .avmm_reset_ssr_clk_rst (rst),
      .sr_enable              (a_en),
      .ssr_par_data_in        (a_par),
      .ssr_load               (a_load),
      .ssr_sdata_out          (a_sdata),
      .ssr_sof_out            (a_sof),
      .ssr_frame_done         (a_done),
      .ssr_busy               (a_busy),
      .ssr_frame_cnt          (a_cnt)
   );

   c3aibadapt_avmm_ssr_tx #(.DWIDTH(1), .GAP_CYCLES(0)) u_dut_b (
      .avmm_clock_ssr_clk     (clk),
      .avmm_reset_ssr_clk_rst (rst),
      .sr_enable              (b_en),
      .ssr_par_data_in        (b_par),
      .ssr_load               (b_load),
      .ssr_sdata_out          (b_sdata),
      .ssr_sof_out            (b_sof),
      .ssr_frame_done         (b_done),
      .ssr_busy               (b_busy),
      .ssr_frame_cnt          (b_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // t counts cycles from an ssr_load of a running default-instance stream.
   task automatic chk_a_cycle(input int t, input logic [7:0] d);
      int   tm;
      logic eb;
      tm = t % 12;
      eb = (tm >= 2 && tm <= 9) ? d[tm-2] : 1'b0;
      chk("a load",  a_load,  (tm == 0));
      chk("a sof",   a_sof,   (tm == 2));
      chk("a done",  a_done,  (tm == 9));
      chk("a sdata", a_sdata, eb);
      chk("a busy",  a_busy,  1'b1);
   endtask

   task automatic chk_a_idle(input int cnt);
      chk("a idle load", a_load, 1'b0);
      chk("a idle busy", a_busy, 1'b0);
      chk("a idle cnt",  a_cnt,  cnt);
   endtask

   // Frame monitor: assembles serial bits from sof to frame_done and scores them.
   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0;
      end else begin
         if (a_sof) begin
            mon_act  = 1'b1;
            mon_idx  = 0;
            mon_word = '0;
         end
         if (mon_act && mon_idx < 8) mon_word[mon_idx] = a_sdata;
         if (a_done) begin
            chk("frame length", mon_idx, 7);
            if (exp_q.size() == 0) chk("frame expected", exp_q.size(), 1);
            else                   chk("frame word", mon_word, exp_q.pop_front());
            mon_act = 1'b0;
         end else if (mon_act) begin
            mon_idx++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nload;
      rst = 1'b1; a_en = 1'b0; b_en = 1'b0; a_par = '0; b_par = '0;
      repeat (3) @(negedge clk);
      chk("rst a load",  a_load,  1'b0);
      chk("rst a sdata", a_sdata, 1'b0);
      chk("rst a sof",   a_sof,   1'b0);
      chk("rst a done",  a_done,  1'b0);
      chk("rst a busy",  a_busy,  1'b0);
      chk("rst a cnt",   a_cnt,   8'd0);
      chk("rst b busy",  b_busy,  1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk_a_idle(0);

      // A5 stream: 12-cycle period, bits 1,0,1,0,0,1,0,1 then two zero gap bits.
      a_par = 8'hA5; a_en = 1'b1;
      exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
      for (int t = 0; t < 24; t++) begin
         @(negedge clk);
         chk_a_cycle(t, 8'hA5);
         if (t == 23) a_en = 1'b0;
      end
      @(negedge clk);
      chk_a_idle(2);

      // Data change on the load cycle is captured; change during SHIFT waits.
      a_par = 8'h00; a_en = 1'b1;
      exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         chk_a_cycle(j, (j < 12) ? 8'hFF : 8'h3C);
         if (j == 0) a_par = 8'hFF;
         if (j == 3) a_par = 8'h3C;
         if (j == 17) begin
            chk("cnt before drop", a_cnt, 8'd3);
            a_en = 1'b0;
         end
      end
      @(negedge clk);
      chk_a_idle(4);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk("no load after drop", a_load, 1'b0);
      end

      // Reset during bit 5 of a frame, then restart.
      a_par = 8'hE7; a_en = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk_a_cycle(j, 8'hE7);
      end
      rst = 1'b1;
      #1;
      chk("mid rst load",  a_load,  1'b0);
      chk("mid rst sdata", a_sdata, 1'b0);
      chk("mid rst sof",   a_sof,   1'b0);
      chk("mid rst done",  a_done,  1'b0);
      chk("mid rst busy",  a_busy,  1'b0);
      chk("mid rst cnt",   a_cnt,   8'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(8'hE7);
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         chk_a_cycle(j, 8'hE7);
         if (j == 11) a_en = 1'b0;
      end
      @(negedge clk);
      chk_a_idle(1);

      // DWIDTH=1, GAP=0: 3-cycle period, sof and done on the single bit.
      b_en = 1'b1;
      for (int t = 0; t < 9; t++) begin
         @(negedge clk);
         chk("b load",  b_load,  (t % 3 == 0));
         chk("b sof",   b_sof,   (t % 3 == 2));
         chk("b done",  b_done,  (t % 3 == 2));
         chk("b sdata", b_sdata, (t % 3 == 2) && ((t / 3) % 2 == 0));
         chk("b busy",  b_busy,  1'b1);
         if (t % 3 == 0) b_par = ((t / 3) % 2 == 0) ? 1'b1 : 1'b0;
         if (t == 8) b_en = 1'b0;
      end
      @(negedge clk);
      chk("b idle busy", b_busy, 1'b0);
      chk("b idle load", b_load, 1'b0);
      chk("b cnt",       b_cnt,  8'd3);

      // 256 back-to-back frames: counter wraps, load cadence unbroken.
      a_par = 8'hC3; a_en = 1'b1; nload = 0;
      for (int k = 0; k < 256; k++) exp_q.push_back(8'hC3);
      for (int t = 0; t < 256 * 12; t++) begin
         @(negedge clk);
         chk_a_cycle(t, 8'hC3);
         if (a_load) nload++;
         if (t % 12 == 10) chk("wrap cnt", a_cnt, 32'((2 + t / 12) % 256));
         if (t == 256 * 12 - 1) a_en = 1'b0;
      end
      @(negedge clk);
      chk("load count", nload, 256);
      chk_a_idle(1);

      chk("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
